// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
package icache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_OFF_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FILL   = 3'd3,
        ST_REPLAY = 3'd4
    } state_e;

endpackage

// File: rtl/icache_refill_timer.sv
// WAIT-state timer: synchronous clear, count enable, terminal flag at TIMEOUT.
module icache_refill_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign done_o = (cnt_q == CNT_W'(TIMEOUT));

    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !done_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: stalls the core, fetches the missing word, writes and replays it.
// Optional ICACHE_REFILL_PERF_EN adds saturating miss/stall counters.
module icache_refill
    import icache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_i,
    input  logic              hit_i,
    output logic              stall_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic              cache_we_o,
    output logic [DATA_W-1:0] cache_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              timeout_o
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_REQ    = ST_REQ;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_FILL   = ST_FILL;
    localparam logic [2:0] S_REPLAY = ST_REPLAY;

    logic [2:0]                   state_q, state_d;
    logic                         lookup_q;
    logic [ADDR_W-1:WORD_OFF_W]   pc_q;
    logic [ADDR_W-1:0]            miss_addr_q;
    logic [DATA_W-1:0]            data_q;
    logic                         in_idle, miss, capture;
    logic                         timer_clr, timer_en, timer_done;

    assign in_idle   = (state_q == S_IDLE);
    assign miss      = lookup_q & ~hit_i;
    assign stall_o   = ~in_idle | miss;
    assign timer_clr = (state_q == S_REQ) & mem_gnt_i;
    assign timer_en  = (state_q == S_WAIT);
    assign capture   = ((state_q == S_REQ) & mem_gnt_i & mem_rvalid_i)
                     | ((state_q == S_WAIT) & mem_rvalid_i);

    icache_refill_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .done_o (timer_done)
    );

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (miss) state_d = S_REQ;
            S_REQ:    if (mem_gnt_i) state_d = mem_rvalid_i ? S_FILL : S_WAIT;
            S_WAIT: begin
                if (mem_rvalid_i)    state_d = S_FILL;
                else if (timer_done) state_d = S_REQ;
            end
            S_FILL:   state_d = S_REPLAY;
            S_REPLAY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // pc_q freezes while stalled so a replay miss re-requests the original address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            lookup_q    <= 1'b0;
            pc_q        <= '0;
            miss_addr_q <= '0;
            data_q      <= '0;
        end else begin
            state_q  <= state_d;
            lookup_q <= (state_q == S_REPLAY) | (fetch_i & ~stall_o);
            if (!stall_o) pc_q <= pc_i[ADDR_W-1:WORD_OFF_W];
            if (in_idle && miss) miss_addr_q <= {pc_q, {WORD_OFF_W{1'b0}}};
            if (capture) data_q <= mem_rdata_i;
        end
    end

    assign cache_addr_o = in_idle ? pc_i : miss_addr_q;
    assign cache_we_o   = (state_q == S_FILL);
    assign cache_data_o = data_q;
    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = mem_req_o ? miss_addr_q : '0;
    assign timeout_o    = (state_q == S_WAIT) & timer_done & ~mem_rvalid_i;

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (in_idle && miss && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 1'b1;
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_icache_refill;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] pc_i = '0;
    logic        fetch_i = 1'b0;
    logic        hit_i = 1'b0;
    logic        stall_o;
    logic [31:0] cache_addr_o;
    logic        cache_we_o;
    logic [31:0] cache_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        timeout_o;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] miss_cnt_o, stall_cnt_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    icache_refill #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .pc_i         (pc_i),
        .fetch_i      (fetch_i),
        .hit_i        (hit_i),
        .stall_o      (stall_o),
        .cache_addr_o (cache_addr_o),
        .cache_we_o   (cache_we_o),
        .cache_data_o (cache_data_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .timeout_o    (timeout_o)
`ifdef ICACHE_REFILL_PERF_EN
        ,
        .miss_cnt_o   (miss_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Transaction-level reference: a refill is a record that progresses through
    // "awaiting grant", "awaiting data" (with a wait counter), "write", "replay".
    bit          m_look;
    logic [31:0] m_look_pc;
    bit          m_busy, m_need_gnt;
    int          m_waited, m_post;   // m_post: 0 no data yet, 2 write cycle, 1 replay cycle
    logic [31:0] m_addr, m_data;
    int          m_misses, m_stalls;

    task automatic model_reset();
        m_look = 0; m_look_pc = '0; m_busy = 0; m_need_gnt = 0;
        m_waited = 0; m_post = 0; m_addr = '0; m_data = '0;
        m_misses = 0; m_stalls = 0;
    endtask

    initial begin : compare
        bit e_miss, e_stall, e_req, e_we, e_to;
        bit nxt_look;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_ni) model_reset();
            e_miss  = m_look && !hit_i;
            e_stall = m_busy || e_miss;
            e_req   = m_busy && m_need_gnt;
            e_we    = m_busy && m_post == 2;
            e_to    = m_busy && !m_need_gnt && m_post == 0 && m_waited == TO && !mem_rvalid_i;
            check("m_stall", stall_o, e_stall);
            check("m_cache_addr", cache_addr_o, m_busy ? m_addr : pc_i);
            check("m_cache_we", cache_we_o, e_we);
            check("m_cache_data", cache_data_o, m_data);
            check("m_mem_req", mem_req_o, e_req);
            check("m_mem_addr", mem_addr_o, e_req ? m_addr : 32'h0);
            check("m_timeout", timeout_o, e_to);
`ifdef ICACHE_REFILL_PERF_EN
            check("m_miss_cnt", miss_cnt_o, m_misses);
            check("m_stall_cnt", stall_cnt_o, m_stalls);
`endif
            if (!rst_ni) continue;
            nxt_look = (m_busy && m_post == 1) || (fetch_i && !e_stall);
            if (e_stall) m_stalls++;
            if (!m_busy) begin
                if (e_miss) begin
                    m_busy = 1; m_need_gnt = 1; m_post = 0;
                    m_addr = {m_look_pc[31:2], 2'b00};
                    m_misses++;
                end
            end else if (m_need_gnt) begin
                if (mem_gnt_i) begin
                    m_need_gnt = 0; m_waited = 0;
                    if (mem_rvalid_i) begin m_data = mem_rdata_i; m_post = 2; end
                end
            end else if (m_post == 0) begin
                if (mem_rvalid_i) begin m_data = mem_rdata_i; m_post = 2; end
                else if (m_waited == TO) m_need_gnt = 1;
                else m_waited++;
            end else if (m_post == 2) begin
                m_post = 1;
            end else begin
                m_busy = 0; m_post = 0;
            end
            if (!e_stall) m_look_pc = pc_i;
            m_look = nxt_look;
        end
    end

    task automatic drive(input logic f, input logic [31:0] pc, input logic h,
                         input logic g, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        fetch_i = f; pc_i = pc; hit_i = h;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
        #3;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int s;
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Hit path
        drive(1, 32'h100, 0, 0, 0, 0);
        check("hit_first_stall", stall_o, 0);
        drive(0, 32'h104, 1, 0, 0, 0);
        check("hit_stall", stall_o, 0);
        check("hit_no_req", mem_req_o, 0);
        check("hit_cache_addr", cache_addr_o, 32'h104);

        // Simple miss at 0x404, rvalid the cycle after gnt
        drive(1, 32'h404, 1, 0, 0, 0);
        drive(1, 32'h404, 0, 0, 0, 0);
        check("miss_detect_stall", stall_o, 1);
        s = int'(stall_o);
        drive(0, 32'h0, 1, 1, 0, 0);
        check("miss_req", mem_req_o, 1);
        check("miss_req_addr", mem_addr_o, 32'h404);
        s += int'(stall_o);
        drive(0, 32'h0, 0, 0, 1, 32'hDEADBEEF);
        check("miss_wait_req_low", mem_req_o, 0);
        s += int'(stall_o);
        drive(0, 32'h0, 0, 0, 0, 0);
        check("miss_fill_we", cache_we_o, 1);
        check("miss_fill_addr", cache_addr_o, 32'h404);
        check("miss_fill_data", cache_data_o, 32'hDEADBEEF);
        s += int'(stall_o);
        drive(0, 32'h0, 0, 0, 0, 0);
        check("miss_replay_we", cache_we_o, 0);
        check("miss_replay_addr", cache_addr_o, 32'h404);
        s += int'(stall_o);
        drive(1, 32'h404, 1, 0, 0, 0);
        check("miss_release_stall", stall_o, 0);
        check("miss_stall_cycles", s, 5);

        // Same-cycle gnt+rvalid at 0x8 skips WAIT
        drive(1, 32'h8, 1, 0, 0, 0);
        check("sc_hit_stall", stall_o, 0);
        drive(1, 32'h8, 0, 0, 0, 0);
        drive(0, 32'h0, 0, 1, 1, 32'h13);
        check("sc_req_addr", mem_addr_o, 32'h8);
        drive(0, 32'h0, 0, 0, 0, 0);
        check("sc_fill_we", cache_we_o, 1);
        check("sc_fill_data", cache_data_o, 32'h13);
        check("sc_fill_addr", cache_addr_o, 32'h8);
        drive(0, 32'h0, 0, 0, 0, 0);
        drive(0, 32'h0, 1, 0, 0, 0);
        check("sc_release_stall", stall_o, 0);

        // Timeout with TIMEOUT=4: unaligned pc 0x22 requests 0x20
        drive(1, 32'h22, 0, 0, 0, 0);
        drive(1, 32'h22, 0, 0, 0, 0);
        check("to_miss_stall", stall_o, 1);
        drive(0, 32'h0, 0, 1, 0, 0);
        check("to_req_addr", mem_addr_o, 32'h20);
        for (int i = 0; i <= TO; i++) begin
            drive(0, 32'h0, 0, 0, 0, 0);
            check($sformatf("to_pulse_%0d", i), timeout_o, (i == TO));
        end
        drive(0, 32'h0, 0, 1, 1, 32'hCAFE0001);
        check("to_reissue_req", mem_req_o, 1);
        check("to_reissue_addr", mem_addr_o, 32'h20);
        check("to_reissue_no_pulse", timeout_o, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        check("to_fill_data", cache_data_o, 32'hCAFE0001);
        check("to_fill_we", cache_we_o, 1);
        drive(0, 32'h0, 0, 0, 0, 0);
        drive(0, 32'h0, 1, 0, 0, 0);
        check("to_release_stall", stall_o, 0);
`ifdef ICACHE_REFILL_PERF_EN
        check("perf_miss_cnt", miss_cnt_o, 3);
        check("perf_stall_cnt", stall_cnt_o, 19);
`endif

        // Reset in the middle of WAIT
        drive(1, 32'h30, 0, 0, 0, 0);
        drive(1, 32'h30, 0, 0, 0, 0);
        drive(0, 32'h0, 0, 1, 0, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        check("rst_pre_stall", stall_o, 1);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_we", cache_we_o, 0);
        check("rst_data", cache_data_o, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 0, 0, 1, 32'h55);
            check($sformatf("rst_late_rvalid_we_%0d", i), cache_we_o, 0);
            check($sformatf("rst_late_rvalid_stall_%0d", i), stall_o, 0);
        end
`ifdef ICACHE_REFILL_PERF_EN
        check("perf_rst_miss_cnt", miss_cnt_o, 0);
`endif

        // Randomized traffic; pc/fetch churn while stalled must be ignored
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            fetch_i      = ($urandom_range(0, 9) < 8);
            pc_i         = $urandom & 32'h0000_0FFF;
            hit_i        = ($urandom_range(0, 9) < 6);
            mem_gnt_i    = $urandom_range(0, 1);
            mem_rvalid_i = ($urandom_range(0, 9) < 3);
            mem_rdata_i  = $urandom;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss handler and refill controller for the instruction cache; it drives the cache write port.
- Watches the cache hit flag for each fetch and stalls the core on a miss.
- Fetches the missing word from backing memory over a req/gnt/rvalid interface, writes it into the cache, then replays the lookup.
- Sits between core fetch stage, icache write port and the memory bus.

Parameters:
- ADDR_W, 32, fetch/memory address width.
- DATA_W, 32, instruction word width.
- TIMEOUT, 255, max cycles in WAIT before the request is reissued (must be ≥1).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- pc_i  in  ADDR_W  core fetch address.
- fetch_i  in  1  core fetch valid this cycle.
- hit_i  in  1  cache hit for address presented on cache_addr_o previous cycle.
- stall_o  out  1  core must hold pc_i/fetch_i.
- cache_addr_o  out  ADDR_W  address to cache: pc_i in IDLE, latched miss address otherwise.
- cache_we_o  out  1  cache write enable (to cache we_i).
- cache_data_o  out  DATA_W  refill word (to cache inst_i).
- mem_req_o  out  1  memory request.
- mem_addr_o  out  ADDR_W  word-aligned request address ([1:0]=0).
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_W  read data.
- timeout_o  out  1  one-cycle pulse when a WAIT timeout fires.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, lookup_q=0, miss_addr=0, all outputs 0 except cache_addr_o=pc_i.
- Lookup timing:
  - lookup_q <= fetch_i & ~stall_o; pc_q <= pc_i.
  - miss = lookup_q & ~hit_i (1-cycle lookup latency).
- stall_o = (state==IDLE & miss) | (state!=IDLE). Combinational.
- States:
  - IDLE: on miss, miss_addr <= {pc_q[ADDR_W-1:2],2'b00} -> REQ. Otherwise stay.
  - REQ: mem_req_o=1, mem_addr_o=miss_addr, held stable until mem_gnt_i.
    - gnt without rvalid -> WAIT, timer cleared.
    - gnt with rvalid in the same cycle -> capture data -> FILL.
    - rvalid without gnt is ignored.
  - WAIT: mem_req_o=0; timer increments each cycle.
    - rvalid -> data_q <= mem_rdata_i -> FILL.
    - timer==TIMEOUT with no rvalid -> timeout_o pulse, -> REQ (reissue).
    - rvalid on the timeout cycle wins: go to FILL, no pulse.
  - FILL: exactly one cycle. cache_we_o=1, cache_addr_o=miss_addr, cache_data_o=data_q -> REPLAY.
  - REPLAY: one cycle. cache_addr_o=miss_addr, stall held; lookup_q forced 1 so the next IDLE cycle checks hit_i -> IDLE.
    - A miss after replay (e.g. concurrent external write) restarts REQ.
- pc_i/fetch_i changes while stall_o=1 are ignored; the latched miss_addr governs.
- Miss-to-fetch latency with gnt=1 and rvalid the cycle after: 5 stall cycles (REQ, WAIT, FILL, REPLAY, IDLE check).
- Reset mid-refill aborts immediately to IDLE. A late rvalid after reset is ignored because the state is not WAIT/REQ.
- Only one outstanding request at a time.
- cache_data_o is held at data_q outside FILL.

Optional Feature:
- ICACHE_REFILL_PERF_EN defined:
  - adds outputs miss_cnt_o[31:0] (increments on each IDLE->REQ) and stall_cnt_o[31:0] (increments every stall_o cycle).
  - both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, REQ, WAIT, FILL, REPLAY; 3-bit encoding);
  - ADDR_W/DATA_W defaults;
  - word-offset width constant (2).
- One sub-module: icache_refill_timer, a clear/enable counter with a terminal flag at TIMEOUT.

Test Plan:
- Hit path: fetch_i=1, pc_i=0x100, hit_i=1 next cycle -> stall_o=0, no mem_req_o.
- Simple miss:
  - stimulus: pc_i=0x404, hit_i=0; gnt in REQ, rvalid 2 cycles later with 0xDEADBEEF.
  - response: mem_addr_o=0x404; one-cycle cache_we_o with cache_addr_o=0x404, cache_data_o=0xDEADBEEF; stall drops after REPLAY when hit_i=1.
- Same-cycle gnt+rvalid: 0x13 on miss at 0x8 -> REQ->FILL directly, WAIT skipped.
- Timeout, TIMEOUT=4:
  - stimulus: gnt, no rvalid.
  - response: timeout_o pulse after 4 WAIT cycles, mem_req_o reasserted with the same address; rvalid then completes the fill.
- Reset mid-WAIT: rst_ni=0 asynchronously -> outputs 0 at once; a rvalid after release produces no cache_we_o.
- Perf (macro on): 3 misses -> miss_cnt_o=3; stall_cnt_o equals the counted stall cycles.
